uart_rx: RTL
============

Name: uart_rx

Overview:
Asynchronous serial receiver for 8N1 frames: 1 start bit, 8 data bits LSB-first, 1 stop bit. It is the downstream counterpart of the controller's transmitter and consumes the serial line that transmitter drives. It also closes the loopback path used in board bring-up. Received bytes go to a valid/ready holding register so a downstream FIFO can apply backpressure. Framing and overrun errors are flagged.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz.
BAUD_RATE, 115_200, line bit rate.
Derived constant CLKS_PER_BIT = CLK_FREQ / BAUD_RATE, using integer division.
Derived constant HALF_BIT = (CLKS_PER_BIT - 1) / 2, using integer division.

Ports:
clk  input  1  system clock.
rst_n  input  1  reset.
rx  input  1  asynchronous serial line, idle high.
dout  output  8  received byte, stable while dout_valid is high.
dout_valid  output  1  byte available in the holding register.
dout_ready  input  1  consumer accepts dout when dout_valid && dout_ready.
busy  output  1  high whenever the state machine is not in IDLE.
frame_err  output  1  one-cycle pulse: stop bit sampled as 0.
overrun  output  1  one-cycle pulse: a completed byte was dropped because the holding register was full.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-low.
- Reset values:
  - dout=0, dout_valid=0, busy=0, frame_err=0, overrun=0.
  - State IDLE, counters 0, shift register 0.
  - Synchronizer flops set to 1, so no false start is seen on release.
- rx passes through a 2-flop synchronizer. The state machine sees only rx_sync.
- States: IDLE, START_BIT, DATA_BITS, STOP_BIT. clk_cnt is wide enough to hold CLKS_PER_BIT-1. bit_index is 3 bits.
- IDLE:
  - clk_cnt=0, bit_index=0.
  - If rx_sync==0, go to START_BIT.
- START_BIT:
  - clk_cnt increments each cycle.
  - When clk_cnt==HALF_BIT, test the start bit. If it is 0: clk_cnt=0, go to DATA_BITS.
  - If it is 1: glitch; return to IDLE with no flags raised.
- DATA_BITS:
  - When clk_cnt==CLKS_PER_BIT-1, sample the bit into shift[bit_index] (LSB first) and set clk_cnt=0.
  - After bit_index 7 is sampled, bit_index wraps to 0 and the state goes to STOP_BIT.
- STOP_BIT:
  - When clk_cnt==CLKS_PER_BIT-1, sample the stop bit and go to IDLE in the same cycle. There is no wait for the end of the stop bit, so a back-to-back start edge is caught.
  - Stop bit = 1 and holding register empty, or emptied this cycle by a handshake: load dout=shift and set dout_valid=1 on the next cycle.
  - Stop bit = 1 and holding register full with dout_ready=0: pulse overrun. The new byte is discarded and the old dout is kept.
  - Stop bit = 0: pulse frame_err. Nothing is loaded and dout_valid is unchanged.
- Holding register:
  - dout_valid clears on the cycle after a dout_valid && dout_ready handshake, unless a new byte loads in that same cycle. A simultaneous load and accept leaves dout_valid=1 with the new dout.
  - dout and dout_valid are registered outputs.
- Latency: a rx falling edge at cycle 0 gives dout_valid=1 at cycle 4 + HALF_BIT + 9*CLKS_PER_BIT. For CLKS_PER_BIT=10 this is cycle 98.
- Reset mid-frame: with rst_n low for at least one clock edge, every state and output returns to its reset value on that edge. The partial frame is discarded.
- busy = (state != IDLE), decoded from registered state.

Optional Feature:
Macro UART_RX_MAJORITY_EN.
- When defined: a 3-bit history of rx_sync is kept. Every sample point, including the start-bit check and the stop bit, uses the 2-of-3 majority of the last three rx_sync values.
- When undefined: each sample point uses the single rx_sync value at that cycle.
- Latency is identical in both builds.

Test Plan:
1. Parameters CLK_FREQ=1_000_000, BAUD_RATE=100_000 (CLKS_PER_BIT=10). Drive the frame for 0xA5 with dout_ready=1 -> dout=0xA5 and dout_valid high at cycle 98 after the falling edge, high for exactly 1 cycle; busy falls at stop-bit sample.
2. Loopback with the controller's transmitter, same parameters, bytes 0x00, 0xFF, 0x55, 0x3C back to back -> all four received in order with no frame_err and no overrun.
3. A 0 pulse of 3 cycles on idle rx -> START_BIT is aborted at HALF_BIT; no dout_valid, no frame_err; busy returns to 0.
4. Frame 0x81 with stop bit forced to 0 -> frame_err pulses 1 cycle and dout_valid stays 0. The next valid frame 0x42 is received correctly.
5. dout_ready=0, send 0x11 then 0x22 -> dout stays 0x11 and overrun pulses once at the 0x22 stop sample. Raising dout_ready then gives one handshake and dout_valid falls.
6. Assert rst_n=0 for 1 cycle midway through data bit 4 of 0xC3 -> all outputs return to reset values. A following frame 0x7E is received intact. With UART_RX_MAJORITY_EN defined, a 1-cycle glitch at the mid-bit of data bit 2 of 0x00 still yields dout=0x00.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a 2-flop input synchronizer and a valid/ready holding register.
// Define UART_RX_MAJORITY_EN to take every sample point as a 2-of-3 vote of recent rx_sync values.
module uart_rx #(
    parameter int unsigned CLK_FREQ  = 50_000_000,
    parameter int unsigned BAUD_RATE = 115_200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] dout,
    output logic       dout_valid,
    input  logic       dout_ready,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int unsigned HALF_BIT     = (CLKS_PER_BIT - 1) / 2;
    localparam int unsigned CntW         = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] CntLast  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] CntHalf  = CntW'(HALF_BIT);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e          state_q, state_d;
    logic [1:0]      sync_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      dout_q, dout_d;
    logic            dout_valid_q, dout_valid_d;
    logic            frame_err_q, frame_err_d;
    logic            overrun_q, overrun_d;
    logic            rx_sync;
    logic            rx_bit;

    assign rx_sync = sync_q[1];

`ifdef UART_RX_MAJORITY_EN
    // Two previous rx_sync values; the vote includes the current one so latency is unchanged.
    logic [1:0] hist_q;

    always_ff @(posedge clk) begin
        if (!rst_n) hist_q <= 2'b11;
        else        hist_q <= {hist_q[0], rx_sync};
    end

    assign rx_bit = (rx_sync & hist_q[0]) | (rx_sync & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
    assign rx_bit = rx_sync;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        shift_d      = shift_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q && !dout_ready;
        frame_err_d  = 1'b0;
        overrun_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                idx_d = '0;
                if (!rx_sync) state_d = StStart;
            end
            StStart: begin
                if (cnt_q == CntHalf) begin
                    cnt_d   = '0;
                    state_d = rx_bit ? StIdle : StData;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StData: begin
                if (cnt_q == CntLast) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_bit;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = StStop;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStop: begin
                if (cnt_q == CntLast) begin
                    // Return to idle at mid-stop so a back-to-back start edge is not missed.
                    cnt_d   = '0;
                    state_d = StIdle;
                    if (!rx_bit) begin
                        frame_err_d = 1'b1;
                    end else if (!dout_valid_q || dout_ready) begin
                        dout_d       = shift_q;
                        dout_valid_d = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q       <= 2'b11;
            state_q      <= StIdle;
            cnt_q        <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            sync_q       <= {sync_q[0], rx};
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != StIdle);

endmodule
